lamp_bar_arbiter: RTL
=====================

Name: lamp_bar_arbiter

Overview:
- Shares the single 16-lamp bar between N_REQ independent pattern engines.
- Each engine is a lamp-sequencing FSM like the up/down fill engines.
- Grants the bar round-robin and supplies the granted engine's step-enable tick from a clock prescaler.
- Muxes the granted pattern to the bar, enforces a fairness timeout, and inserts a blank guard between owners.

Parameters:
N_REQ, 3, number of pattern engines (2..8)
TICK_DIV, 4, clk cycles per step tick (>=2)
MAX_TICKS, 8, ticks an owner keeps the bar while another engine is requesting
BLANK_CYC, 2, clk cycles the bar is forced dark between owners (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  N_REQ  engine i requests the bar; level, held until done or withdrawn
done  in  N_REQ  engine i finished its pattern; 1-cycle pulse, honoured only from the owner
pat_in  in  16*N_REQ  engine i pattern in slice [16i+15:16i]
gnt  out  N_REQ  one-hot grant; registered
tick  out  1  step-enable pulse, 1 clk wide, meaningful only to the granted engine
lamp  out  16  lamp bar drive; registered
busy  out  1  high in ARB, SERVE and BLANK

Behaviour:
- Reset (asynchronous, any time, including mid-SERVE):
  - state=IDLE; gnt, tick, lamp, busy = 0; rr_ptr=0; prescaler and tick counter = 0.
- States: IDLE, ARB, SERVE, BLANK.
- IDLE:
  - If |req, go to ARB next clk; otherwise stay.
  - lamp=0, gnt=0.
- ARB (exactly 1 clk):
  - Winner = first i with req[i]=1, searching cyclically from rr_ptr.
  - Register owner=winner; set gnt=1<<winner; rr_ptr <= (winner+1) mod N_REQ; go to SERVE.
  - If req dropped to 0 during ARB, return to IDLE with gnt=0.
  - Latency: req sampled high in IDLE at clk k gives gnt high from clk k+2.
- SERVE:
  - Prescaler pcnt clears on entry and counts 0..TICK_DIV-1 then wraps.
  - tick=1 in the cycle following pcnt==TICK_DIV-1, so the first tick comes TICK_DIV clks after SERVE entry, then every TICK_DIV clks.
  - lamp <= owner's pat_in slice every clk (1-clk latency from pat_in to lamp).
  - tcnt increments on each tick and saturates at MAX_TICKS.
- Release from SERVE, evaluated every clk, in priority order:
  1. done[owner]=1 or req[owner]=0: release.
  2. tcnt==MAX_TICKS and any other req[j]=1: release (timeout).
  3. Otherwise stay.
  - done/req from non-owners are ignored for release.
  - Timeout with no other requester: the owner keeps the bar indefinitely with tcnt saturated.
  - On release: gnt=0, tick=0 and lamp=0 from the next clk; go to BLANK.
- BLANK:
  - Lasts exactly BLANK_CYC clks with lamp=0 and gnt=0.
  - Then go to ARB if |req, else IDLE.
- Concurrency rules:
  - A tick coinciding with a release cycle is suppressed; no tick is ever emitted while gnt=0.
  - gnt is never multi-hot; lamp is never driven from a non-owner slice.
- busy=1 exactly in ARB, SERVE and BLANK.

Decomposition:
- Shared package lamp_pkg:
  - LAMP_W=16
  - state enum: IDLE=0, ARB=1, SERVE=2, BLANK=3
  - lamp constants LAMP_OFF=16'h0000 and LAMP_FULL=16'hFFFF
- One sub-module, rr_pick: purely combinational cyclic priority picker.
  - Inputs: req, rr_ptr.
  - Outputs: one-hot win, win_idx, any.
  - Parameterised on N_REQ.

Test Plan:
(Defaults: N_REQ=3, TICK_DIV=4, MAX_TICKS=8, BLANK_CYC=2.)
1. Single request: req=3'b001, pat_in[15:0]=16'h003F, then done[0] pulse after 5 ticks.
   - gnt=001 two clks after req.
   - First tick 4 clks after gnt.
   - lamp=16'h003F one clk after gnt.
   - After done: lamp=0 for 2 clks, then IDLE, busy=0.
2. Round-robin: req=3'b111 held, each owner pulses done after its 2nd tick.
   - Grant order 001, 010, 100, 001.
   - Blank of 2 clks between each.
3. Fairness timeout: req=3'b011, no done.
   - Owner 0 released exactly at its 8th tick; gnt=010 after blank+ARB.
   - Owner 1 released at its 8th tick; gnt returns to 001.
4. No contention: req=3'b001 only, no done.
   - gnt stays 001 past 8 ticks.
   - tick keeps pulsing every 4 clks.
5. Withdraw: owner 2 drops req mid-SERVE.
   - Next clk gnt=0 and lamp=0, no further tick.
   - A non-owner done pulse earlier in the same run causes no release.
6. Reset mid-SERVE: assert rst_n=0 between clk edges.
   - gnt, tick, lamp and busy go to 0 immediately.
   - After release with req=3'b100: grant goes to requester 2 via a fresh search from rr_ptr=0.

Source files
------------

// File: rtl/lamp_bar_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lamp_pkg
//  Description : Shared definitions for the lamp bar arbiter: bar width,
//                arbiter state encoding and fixed lamp patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
package lamp_pkg;

    localparam int LAMP_W = 16;

    localparam logic [LAMP_W-1:0] LAMP_OFF  = 16'h0000;
    localparam logic [LAMP_W-1:0] LAMP_FULL = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        SERVE = 2'd2,
        BLANK = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lamp_bar_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational cyclic priority picker. Finds the first set
//                request bit starting at i_rr_ptr and wrapping around.
//  Ports       : i_req     - request vector
//                i_rr_ptr  - index where the search starts
//                o_win     - one-hot winner (zero when no request)
//                o_win_idx - binary index of the winner
//                o_any     - at least one request is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [N_REQ-1:0] o_win,
    output logic [IDX_W-1:0] o_win_idx,
    output logic             o_any
);

    // One extra bit so ptr + offset (at most 2*N_REQ-2) never overflows
    // before the modulo wrap.
    localparam int                 c_SUM_W = IDX_W + 1;
    localparam logic [c_SUM_W-1:0] c_N     = c_SUM_W'(N_REQ);

    logic [c_SUM_W-1:0] w_sum;
    logic [IDX_W-1:0]   w_sel;

    always_comb begin
        o_win     = '0;
        o_win_idx = '0;
        o_any     = 1'b0;
        w_sum     = '0;
        w_sel     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, i_rr_ptr} + c_SUM_W'(k);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_sel = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_sel]) begin
                o_any        = 1'b1;
                o_win[w_sel] = 1'b1;
                o_win_idx    = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lamp_bar_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lamp_bar_arbiter
//  Description : Shares one 16-lamp bar between N_REQ pattern engines.
//                Round-robin grant, prescaled step tick for the owner,
//                fairness timeout and a dark guard interval between owners.
//  Ports       : clk     - clock
//                rst_n   - asynchronous active-low reset
//                req     - per-engine bar request (level)
//                done    - per-engine pattern finished (pulse, owner only)
//                pat_in  - engine i pattern in [16i+15:16i]
//                gnt     - registered one-hot grant
//                tick    - step-enable pulse for the granted engine
//                lamp    - registered lamp bar drive
//                busy    - arbiter in ARB, SERVE or BLANK
//  Revision    : 1.0 - initial release
// ============================================================================
module lamp_bar_arbiter
    import lamp_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int TICK_DIV  = 4,
    parameter int MAX_TICKS = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          done,
    input  logic [LAMP_W*N_REQ-1:0]   pat_in,
    output logic [N_REQ-1:0]          gnt,
    output logic                      tick,
    output logic [LAMP_W-1:0]         lamp,
    output logic                      busy
);

    localparam int c_IDX_W  = $clog2(N_REQ);
    localparam int c_PCNT_W = $clog2(TICK_DIV);
    localparam int c_TCNT_W = $clog2(MAX_TICKS + 1);
    localparam int c_BCNT_W = $clog2(BLANK_CYC + 1);

    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(N_REQ - 1);
    localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(TICK_DIV - 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_MAX  = c_TCNT_W'(MAX_TICKS);
    localparam logic [c_BCNT_W-1:0] c_BCNT_LAST = c_BCNT_W'(BLANK_CYC - 1);

    state_t                r_state;
    logic [N_REQ-1:0]      r_gnt;
    logic                  r_tick;
    logic [LAMP_W-1:0]     r_lamp;
    logic [c_IDX_W-1:0]    r_owner;
    logic [c_IDX_W-1:0]    r_rr_ptr;
    logic [c_PCNT_W-1:0]   r_pcnt;
    logic [c_TCNT_W-1:0]   r_tcnt;
    logic [c_BCNT_W-1:0]   r_bcnt;

    logic [N_REQ-1:0]      w_win;
    logic [c_IDX_W-1:0]    w_win_idx;
    logic                  w_any;
    logic [LAMP_W-1:0]     w_pat_owner;
    logic                  w_own_req;
    logic                  w_own_done;
    logic                  w_other_req;
    logic                  w_release;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_rr_pick (
        .i_req     (req),
        .i_rr_ptr  (r_rr_ptr),
        .o_win     (w_win),
        .o_win_idx (w_win_idx),
        .o_any     (w_any)
    );

    assign w_pat_owner = pat_in[r_owner*LAMP_W +: LAMP_W];

    // r_gnt is one-hot while serving, so it doubles as the owner mask and
    // keeps non-owner done/req bits out of the release decision.
    assign w_own_req   = |(req & r_gnt);
    assign w_own_done  = |(done & r_gnt);
    assign w_other_req = |(req & ~r_gnt);
    assign w_release   = w_own_done || !w_own_req ||
                         ((r_tcnt == c_TCNT_MAX) && w_other_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_tick   <= 1'b0;
            r_lamp   <= LAMP_OFF;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_pcnt   <= '0;
            r_tcnt   <= '0;
            r_bcnt   <= '0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_gnt  <= '0;
                    r_lamp <= LAMP_OFF;
                    if (|req) begin
                        r_state <= ARB;
                    end
                end
                ARB: begin
                    if (w_any) begin
                        r_owner  <= w_win_idx;
                        r_gnt    <= w_win;
                        r_rr_ptr <= (w_win_idx == c_IDX_LAST) ? '0 : w_win_idx + 1'b1;
                        r_pcnt   <= '0;
                        r_tcnt   <= '0;
                        r_state  <= SERVE;
                    end else begin
                        r_gnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                SERVE: begin
                    if (w_release) begin
                        // Any tick due on this edge is dropped with the grant.
                        r_gnt   <= '0;
                        r_lamp  <= LAMP_OFF;
                        r_bcnt  <= '0;
                        r_state <= BLANK;
                    end else begin
                        r_lamp <= w_pat_owner;
                        if (r_pcnt == c_PCNT_LAST) begin
                            r_pcnt <= '0;
                            r_tick <= 1'b1;
                            if (r_tcnt != c_TCNT_MAX) begin
                                r_tcnt <= r_tcnt + 1'b1;
                            end
                        end else begin
                            r_pcnt <= r_pcnt + 1'b1;
                        end
                    end
                end
                BLANK: begin
                    r_gnt  <= '0;
                    r_lamp <= LAMP_OFF;
                    if (r_bcnt == c_BCNT_LAST) begin
                        r_state <= (|req) ? ARB : IDLE;
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign tick = r_tick;
    assign lamp = r_lamp;
    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire
